adam_aes_decipher_block: RTL

ADAM_AES_DECIPHER_BLOCK -- requirements
Module: adam_aes_decipher_block

---
 rtl/adam_aes_pkg.sv | 30 +++
 rtl/adam_aes_inv_sbox.sv | 33 +++
 rtl/adam_aes_decipher_block.sv | 124 ++++++++++++
 3 files changed

// File: rtl/adam_aes_pkg.sv
// adam_aes_pkg: shared AES decipher constants, FSM states and the GF(2^8)
// multipliers used by InvMixColumns.
package adam_aes_pkg;
  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;
  localparam logic KEYLEN_128 = 1'b0;
  localparam logic KEYLEN_256 = 1'b1;

  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_e;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return xt(xt(xt(b)) ^ b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return xt(xt(xt(b) ^ b)) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return xt(xt(xt(b) ^ b) ^ b);
  endfunction
endpackage

// File: rtl/adam_aes_inv_sbox.sv
// adam_aes_inv_sbox: combinational inverse S-box on a 32-bit word; each byte is
// the inverse affine map followed by the GF(2^8) multiplicative inverse.
module adam_aes_inv_sbox (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), x);
    return gmul(r, r);
  endfunction

  function automatic logic [7:0] inv_byte(input logic [7:0] b);
    return ginv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_byte
    assign o_word[8*g +: 8] = inv_byte(i_word[8*g +: 8]);
  end
endmodule

// File: rtl/adam_aes_decipher_block.sv
// adam_aes_decipher_block: iterative AES-128/256 decryption, round keys fetched by index.
// Define AES_DEC_PARALLEL_SBOX_EN to substitute all four state words in one SBOX cycle.
module adam_aes_decipher_block
  import adam_aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);
  state_e       r_fsm, w_fsm_nxt;
  logic [3:0]   r_round_ctr, w_round_nxt;
  logic [1:0]   r_sword_ctr, w_sword_nxt;
  logic         r_keylen, w_keylen_nxt, r_ready, w_ready_nxt, w_sbox_last;
  logic [127:0] r_state, w_state_nxt, w_sbox_state;

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm9(a3),
                           gm9(a0) ^ gm14(a1) ^ gm11(a2) ^ gm13(a3),
                           gm13(a0) ^ gm9(a1) ^ gm14(a2) ^ gm11(a3),
                           gm11(a0) ^ gm13(a1) ^ gm9(a2) ^ gm14(a3)};
    end
    return o;
  endfunction

`ifdef AES_DEC_PARALLEL_SBOX_EN
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    adam_aes_inv_sbox u_inv_sbox (.i_word(r_state[32*g +: 32]), .o_word(w_sbox_state[32*g +: 32]));
  end
  assign w_sbox_last = 1'b1;
`else
  logic [1:0]  w_sel;
  logic [31:0] w_sub;
  // word 0 is the most significant, so the slice index counts down
  assign w_sel = 2'd3 - r_sword_ctr;
  adam_aes_inv_sbox u_inv_sbox (.i_word(r_state[{w_sel, 5'd0} +: 32]), .o_word(w_sub));
  always_comb begin
    w_sbox_state = r_state;
    w_sbox_state[{w_sel, 5'd0} +: 32] = w_sub;
  end
  assign w_sbox_last = r_sword_ctr == 2'd3;
`endif

  always_comb begin
    w_fsm_nxt    = r_fsm;
    w_round_nxt  = r_round_ctr;
    w_sword_nxt  = r_sword_ctr;
    w_keylen_nxt = r_keylen;
    w_ready_nxt  = r_ready;
    w_state_nxt  = r_state;
    case (r_fsm)
      IDLE: if (next) begin
        w_round_nxt  = keylen == KEYLEN_256 ? AES256_ROUNDS : AES128_ROUNDS;
        w_keylen_nxt = keylen;
        w_sword_nxt  = '0;
        w_ready_nxt  = 1'b0;
        w_fsm_nxt    = INIT;
      end
      INIT: begin
        w_state_nxt = inv_shift_rows(block ^ round_key);
        w_round_nxt = r_round_ctr - 4'd1;
        w_sword_nxt = '0;
        w_fsm_nxt   = SBOX;
      end
      SBOX: begin
        w_state_nxt = w_sbox_state;
        w_sword_nxt = w_sbox_last ? 2'd0 : r_sword_ctr + 2'd1;
        w_fsm_nxt   = w_sbox_last ? MAIN : SBOX;
      end
      MAIN: if (r_round_ctr != 4'd0) begin
        w_state_nxt = inv_shift_rows(inv_mix_columns(r_state ^ round_key));
        w_round_nxt = r_round_ctr - 4'd1;
        w_fsm_nxt   = SBOX;
      end else begin
        w_state_nxt = r_state ^ round_key;
        w_ready_nxt = 1'b1;
        w_fsm_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm       <= IDLE;
      r_round_ctr <= '0;
      r_sword_ctr <= '0;
      r_keylen    <= KEYLEN_128;
      r_ready     <= 1'b1;
      r_state     <= '0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_round_ctr <= w_round_nxt;
      r_sword_ctr <= w_sword_nxt;
      r_keylen    <= w_keylen_nxt;
      r_ready     <= w_ready_nxt;
      r_state     <= w_state_nxt;
    end
  end

  // the first key fetched must be the last round key of the captured key length
  a_init_round: assert property (@(posedge clk) disable iff (!reset_n)
    r_fsm == INIT |-> r_round_ctr == (r_keylen == KEYLEN_256 ? AES256_ROUNDS : AES128_ROUNDS));

  assign round     = r_round_ctr;
  assign new_block = r_state;
  assign ready     = r_ready;
endmodule
